knn_mem_stream_ctrl: RTL and testbench
======================================

// Module: knn_mem_stream_ctrl
// PURPOSE
//  Next-gen KNN memory controller. Loads a batch of NCH input vectors into registers, then streams
//  all L training vectors word-by-word to the distance units. Transfers use valid/ready with
//  back-pressure over a pipelined fixed-latency memory port. Writes back NCH inferred types and
//  repeats for cfg_n_batch batches. Sits between on-chip RAM and the distance/vote datapath.
// PARAMETERS
//  W=32            data word width
//  DIM=16          elements per vector
//  TYPE_W=4        class-type width
//  L=8             training vectors per pass
//  NCH=2           input vectors per batch (channels)
//  ADDR_W=16       memory address width
//  ADDR_STEP=4     address increment per word
//  BASE_T_ADDR=0   training base; record = type word + DIM data words
//  BASE_I_ADDR=1024 input base; record = result slot word + DIM data words
//  RD_LAT=2        cycles from rd_en to rd_data valid (>=1)
// PORTS
//  clk            in  1               clock
//  rst_n          in  1               synchronous reset, active low
//  start          in  1               begin job (sampled in IDLE only)
//  cfg_n_batch    in  16              number of batches; latched at start
//  busy           out 1               high from start acceptance to done
//  done           out 1               1-cycle pulse at job end
//  rd_en          out 1               memory read strobe
//  rd_addr        out ADDR_W          read address
//  rd_data        in  W               read data, valid RD_LAT cycles after rd_en
//  wr_en          out 1               memory write strobe
//  wr_addr        out ADDR_W          write address
//  wr_data        out W               write data
//  in_vec         out NCH*DIM*W       input vectors; ch c, elem e at [(c*DIM+e)*W +: W]
//  in_valid       out 1               in_vec stable and valid
//  t_data         out W               training element
//  t_type         out TYPE_W          type of the current training vector
//  t_last         out 1               last element of the vector
//  t_valid        out 1               stream valid
//  t_ready        in  1               stream ready
//  infer_valid    in  1               inferred types ready (sampled in WAIT_INF only)
//  infer_type     in  NCH*TYPE_W      per-channel inferred type
// BEHAVIOUR
//  Reset: busy, done, rd_en, wr_en, in_valid, t_valid, t_last = 0; addresses, data, types = 0.
//   Read-valid pipeline and FIFO are flushed; in-flight returns are dropped.
//  FSM: IDLE -> LOAD_IN -> STREAM -> WAIT_INF -> WRITE -> (next batch ? LOAD_IN : FIN) -> IDLE.
//  IDLE: start=1 latches cfg_n_batch and sets busy; cfg_n_batch=0 -> FIN directly (no memory access).
//  LOAD_IN: one read per cycle, NCH*DIM reads, skipping each slot word. Returns are written into in_vec.
//   After the last return: in_valid=1, go to STREAM. in_valid stays 1 until WRITE ends.
//  STREAM: per training vector, read the type word, then DIM data words, in address order.
//   A returned type word updates the pending-type register and is not pushed.
//   Data returns go to the FIFO (depth RD_LAT+2) as {data,type,last}.
//  Credit rule: issue a read only if outstanding + FIFO occupancy < depth; no word is ever lost.
//  Transfer occurs when t_valid & t_ready. Leave STREAM after the L*DIM-th transfer (t_last on each DIM-th).
//  WAIT_INF: wait for infer_valid and latch infer_type. infer_valid outside WAIT_INF is ignored.
//  WRITE: NCH consecutive cycles, wr_en=1, wr_addr=slot of channel c,
//   wr_data = zero-extended type c. Then input base += NCH*(DIM+1)*ADDR_STEP; training restarts at BASE_T_ADDR.
//  FIN: done=1 for one cycle, busy=0 next cycle. start while busy is ignored.
//  Address arithmetic wraps modulo 2^ADDR_W. rd_en and wr_en are never high in the same cycle.
// CONFIGURATION
//  KNN_MEM_PERF_EN defined: adds outputs perf_busy[31:0] (cycles busy=1) and perf_stall[31:0]
//   (cycles t_valid & !t_ready). Both clear on start acceptance and saturate at all-ones.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  T1 defaults, cfg_n_batch=1, t_ready=1, RAM holds the word index -> in_vec ch1 e0 = word 18;
//   128 transfers, 8 t_last; infer 3,5 -> writes 3 @1024 and 5 @1092; done 1 cycle.
//  T2 cfg_n_batch=0, start -> done on cycle 2, zero rd_en/wr_en.
//  T3 t_ready toggles 1-of-3 cycles -> stream matches T1 order exactly; outstanding never exceeds FIFO depth.
//  T4 cfg_n_batch=2 -> second load starts at 1160; training re-read from 0; 4 writes total.
//  T5 rst_n=0 mid-STREAM for 1 cycle -> all outputs at reset values next cycle; a fresh start replays T1.
//  T6 infer_valid pulsed during STREAM -> ignored; FSM stays in WAIT_INF until a new pulse.

Source files
------------

// File: rtl/knn_mem_stream_ctrl.sv
// KNN memory stream controller: batch input load, credit-based training stream, result write-back.
// Optional perf counters enabled by defining KNN_MEM_PERF_EN.
module knn_mem_stream_ctrl #(
  parameter int W           = 32,
  parameter int DIM         = 16,
  parameter int TYPE_W      = 4,
  parameter int L           = 8,
  parameter int NCH         = 2,
  parameter int ADDR_W      = 16,
  parameter int ADDR_STEP   = 4,
  parameter int BASE_T_ADDR = 0,
  parameter int BASE_I_ADDR = 1024,
  parameter int RD_LAT      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [15:0]           cfg_n_batch,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [W-1:0]          rd_data,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [W-1:0]          wr_data,
  output logic [NCH*DIM*W-1:0]  in_vec,
  output logic                  in_valid,
  output logic [W-1:0]          t_data,
  output logic [TYPE_W-1:0]     t_type,
  output logic                  t_last,
  output logic                  t_valid,
  input  logic                  t_ready,
  input  logic                  infer_valid,
  input  logic [NCH*TYPE_W-1:0] infer_type
`ifdef KNN_MEM_PERF_EN
  ,
  output logic [31:0]           perf_busy,
  output logic [31:0]           perf_stall
`endif
);

  localparam int DEPTH = RD_LAT + 2;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int NIN   = NCH * DIM;
  localparam int LIW   = $clog2(NIN + 1);
  localparam int WW    = $clog2(DIM + 1);
  localparam int VW    = $clog2(L + 1);
  localparam int XW    = $clog2(L * DIM + 1);
  localparam int NW    = $clog2(NCH + 1);

  localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(ADDR_STEP);
  localparam logic [ADDR_W-1:0] STEP_2 = ADDR_W'(2 * ADDR_STEP);
  localparam logic [ADDR_W-1:0] REC_A  = ADDR_W'((DIM + 1) * ADDR_STEP);
  localparam logic [ADDR_W-1:0] BINC_A = ADDR_W'(NCH * (DIM + 1) * ADDR_STEP);
  localparam logic [ADDR_W-1:0] BT_A   = ADDR_W'(BASE_T_ADDR);
  localparam logic [ADDR_W-1:0] BI_A   = ADDR_W'(BASE_I_ADDR);

  typedef enum logic [2:0] {
    IDLE, LOAD_IN, STREAM, WAIT_INF, WRITE, FIN
  } state_t;

  state_t                state;
  logic [15:0]           nb;
  logic [15:0]           bcnt;
  logic [ADDR_W-1:0]     base_i;
  logic [ADDR_W-1:0]     na;
  logic [LIW-1:0]        iss;
  logic [LIW-1:0]        ret;
  logic [WW-1:0]         elem;
  logic [WW-1:0]         s_word;
  logic [VW-1:0]         s_vec;
  logic [XW-1:0]         xfer;
  logic [NW-1:0]         wcnt;
  logic [NCH*TYPE_W-1:0] inf;
  logic [TYPE_W-1:0]     ptype;
  logic                  rd_type;
  logic                  rd_last;
  logic [RD_LAT-1:0]     vpipe;
  logic [RD_LAT-1:0]     tpipe;
  logic [RD_LAT-1:0]     lpipe;

  logic [W-1:0]          f_data [DEPTH];
  logic [TYPE_W-1:0]     f_type [DEPTH];
  logic                  f_last [DEPTH];
  logic [PW-1:0]         wp;
  logic [PW-1:0]         rp;
  logic [CW-1:0]         cnt;

  logic                  ret_v;
  logic                  ret_type;
  logic                  ret_last;
  logic                  push;
  logic                  pop;
  logic                  credit;
  logic [CW-1:0]         outs;

  assign ret_v    = vpipe[RD_LAT-1];
  assign ret_type = tpipe[RD_LAT-1];
  assign ret_last = lpipe[RD_LAT-1];
  assign t_valid  = (cnt != '0);
  assign t_data   = f_data[rp];
  assign t_type   = f_type[rp];
  assign t_last   = f_last[rp];
  assign pop      = t_valid & t_ready;
  assign push     = ret_v & ~ret_type & (state == STREAM);

  // Every read in flight (type words included) holds a FIFO slot.
  always_comb begin
    outs = CW'(rd_en);
    for (int i = 0; i < RD_LAT; i++) begin
      outs = outs + CW'(vpipe[i]);
    end
  end

  assign credit = ({1'b0, outs} + {1'b0, cnt}) < (CW + 1)'(DEPTH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      in_vec   <= '0;
      in_valid <= 1'b0;
      nb       <= '0;
      bcnt     <= '0;
      base_i   <= '0;
      na       <= '0;
      iss      <= '0;
      ret      <= '0;
      elem     <= '0;
      s_word   <= '0;
      s_vec    <= '0;
      xfer     <= '0;
      wcnt     <= '0;
      inf      <= '0;
      ptype    <= '0;
      rd_type  <= 1'b0;
      rd_last  <= 1'b0;
      vpipe    <= '0;
      tpipe    <= '0;
      lpipe    <= '0;
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        f_data[i] <= '0;
        f_type[i] <= '0;
        f_last[i] <= 1'b0;
      end
    end else begin
      done  <= 1'b0;
      rd_en <= 1'b0;
      wr_en <= 1'b0;

      vpipe[0] <= rd_en;
      tpipe[0] <= rd_type;
      lpipe[0] <= rd_last;
      for (int i = 1; i < RD_LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
        tpipe[i] <= tpipe[i-1];
        lpipe[i] <= lpipe[i-1];
      end

      if (push) begin
        f_data[wp] <= rd_data;
        f_type[wp] <= ptype;
        f_last[wp] <= ret_last;
        wp <= (wp == PW'(DEPTH - 1)) ? '0 : wp + PW'(1);
      end
      if (pop) begin
        rp <= (rp == PW'(DEPTH - 1)) ? '0 : rp + PW'(1);
      end
      cnt <= cnt + CW'(push) - CW'(pop);

      unique case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start && !busy) begin
            busy   <= 1'b1;
            nb     <= cfg_n_batch;
            bcnt   <= '0;
            base_i <= BI_A;
            if (cfg_n_batch == 16'd0) begin
              state <= FIN;
            end else begin
              state <= LOAD_IN;
              na    <= BI_A + STEP_A;
              iss   <= '0;
              ret   <= '0;
              elem  <= '0;
            end
          end
        end

        LOAD_IN: begin
          if (iss != LIW'(NIN)) begin
            rd_en   <= 1'b1;
            rd_addr <= na;
            rd_type <= 1'b0;
            rd_last <= 1'b0;
            // Hop over the next record's slot word.
            na   <= na + ((elem == WW'(DIM - 1)) ? STEP_2 : STEP_A);
            elem <= (elem == WW'(DIM - 1)) ? '0 : elem + WW'(1);
            iss  <= iss + LIW'(1);
          end
          if (ret_v) begin
            in_vec[int'(ret)*W +: W] <= rd_data;
            ret <= ret + LIW'(1);
            if (ret == LIW'(NIN - 1)) begin
              in_valid <= 1'b1;
              state    <= STREAM;
              na       <= BT_A;
              s_word   <= '0;
              s_vec    <= '0;
              xfer     <= '0;
            end
          end
        end

        STREAM: begin
          if (s_vec != VW'(L) && credit) begin
            rd_en   <= 1'b1;
            rd_addr <= na;
            na      <= na + STEP_A;
            rd_type <= (s_word == '0);
            rd_last <= (s_word == WW'(DIM));
            if (s_word == WW'(DIM)) begin
              s_word <= '0;
              s_vec  <= s_vec + VW'(1);
            end else begin
              s_word <= s_word + WW'(1);
            end
          end
          if (ret_v && ret_type) begin
            ptype <= rd_data[TYPE_W-1:0];
          end
          if (pop) begin
            xfer <= xfer + XW'(1);
            if (xfer == XW'(L * DIM - 1)) begin
              state <= WAIT_INF;
            end
          end
        end

        WAIT_INF: begin
          if (infer_valid) begin
            inf     <= infer_type;
            state   <= WRITE;
            wcnt    <= '0;
            wr_en   <= 1'b1;
            wr_addr <= base_i;
            wr_data <= {{(W - TYPE_W){1'b0}}, infer_type[TYPE_W-1:0]};
          end
        end

        WRITE: begin
          if (wcnt == NW'(NCH - 1)) begin
            in_valid <= 1'b0;
            base_i   <= base_i + BINC_A;
            bcnt     <= bcnt + 16'd1;
            if (bcnt + 16'd1 == nb) begin
              state <= FIN;
            end else begin
              state <= LOAD_IN;
              na    <= base_i + BINC_A + STEP_A;
              iss   <= '0;
              ret   <= '0;
              elem  <= '0;
            end
          end else begin
            wr_en   <= 1'b1;
            wr_addr <= wr_addr + REC_A;
            wr_data <= {{(W - TYPE_W){1'b0}},
                        inf[(int'(wcnt) + 1)*TYPE_W +: TYPE_W]};
            wcnt    <= wcnt + NW'(1);
          end
        end

        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef KNN_MEM_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_busy  <= '0;
      perf_stall <= '0;
    end else if (state == IDLE && start && !busy) begin
      perf_busy  <= '0;
      perf_stall <= '0;
    end else begin
      if (busy && perf_busy != '1) begin
        perf_busy <= perf_busy + 32'd1;
      end
      if (t_valid && !t_ready && perf_stall != '1) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_knn_mem_stream_ctrl.sv
// Directed bench for knn_mem_stream_ctrl: load, stream order, back-pressure,
// multi-batch, reset abort and stray infer pulses.
module tb_knn_mem_stream_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [15:0]  cfg_n_batch;
  logic         busy, done, rd_en, wr_en, in_valid;
  logic [15:0]  rd_addr, wr_addr;
  logic [31:0]  rd_data, wr_data, t_data;
  logic [1023:0] in_vec;
  logic [3:0]   t_type;
  logic         t_last, t_valid, t_ready, infer_valid;
  logic [7:0]   infer_type;

  knn_mem_stream_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_n_batch(cfg_n_batch),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .in_vec(in_vec), .in_valid(in_valid), .t_data(t_data), .t_type(t_type),
    .t_last(t_last), .t_valid(t_valid), .t_ready(t_ready),
    .infer_valid(infer_valid), .infer_type(infer_type)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // RAM returns its word index, RD_LAT=2 cycles after the strobe.
  logic [15:0] apipe [2];
  always @(negedge clk) begin
    rd_data  = 32'(apipe[1] >> 2);
    apipe[1] = apipe[0];
    apipe[0] = rd_en ? rd_addr : 16'hFFFF;
  end

  logic clr_req = 1'b0;
  int nrd, nwr, nx, nlast, serr, ovf, both, ndone, dreads, ivbad;
  int rd_log [512];
  int wr_a [8];
  int wr_d [8];
  int xk, v, e;

  always @(negedge clk) begin
    if (clr_req) begin
      nrd = 0; nwr = 0; nx = 0; nlast = 0; serr = 0;
      ovf = 0; both = 0; ndone = 0; dreads = 0; ivbad = 0;
    end else begin
      if (rd_en) begin
        if (nrd < 512) rd_log[nrd] = int'(rd_addr);
        nrd++;
        if (rd_addr < 16'd1024 && (rd_addr / 16'd4) % 16'd17 != 16'd0)
          dreads++;
      end
      if (dreads - nx > 4) ovf++;
      if (wr_en) begin
        if (nwr < 8) begin
          wr_a[nwr] = int'(wr_addr);
          wr_d[nwr] = int'(wr_data);
        end
        nwr++;
      end
      if (rd_en && wr_en) both++;
      if (done) ndone++;
      if (t_valid && t_ready) begin
        xk = nx % 128;
        v = xk / 16;
        e = xk % 16;
        if (t_data !== 32'(v * 17 + 1 + e) || t_type !== 4'(v) ||
            t_last !== (e == 15)) serr++;
        if (!in_valid) ivbad++;
        if (t_last) nlast++;
        nx++;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk); #1;
    clr_req = 1'b1;
    @(negedge clk); #1;
    clr_req = 1'b0;
  endtask

  task automatic run_job(input int nb, input int rmode, input bit early,
                         input int budget, output bit ok);
    int pulses, wc;
    bit ep;
    ok = 1'b0; pulses = 0; wc = 0; ep = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; cfg_n_batch = 16'(nb);
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < budget && !ok; cyc++) begin
      t_ready = (rmode == 0) ? 1'b1 : (cyc % 3 == 0);
      infer_valid = 1'b0;
      if (early && !ep && nx >= 20) begin
        infer_valid = 1'b1;
        infer_type = 8'h77;
        ep = 1'b1;
      end else if (pulses < nb && nx >= 128 * (pulses + 1)) begin
        wc++;
        if (wc > 6) begin
          infer_valid = 1'b1;
          infer_type = {4'(5 + 4 * pulses), 4'(3 + 3 * pulses)};
          pulses++;
          wc = 0;
        end
      end
      @(posedge clk); #1;
      if (done) ok = 1'b1;
    end
    infer_valid = 1'b0;
    t_ready = 1'b1;
  endtask

  task automatic check_single(input string tg);
    chk({tg, "_xfers"}, 64'(nx), 64'd128);
    chk({tg, "_lasts"}, 64'(nlast), 64'd8);
    chk({tg, "_order"}, 64'(serr), 64'd0);
    chk({tg, "_credit"}, 64'(ovf), 64'd0);
    chk({tg, "_inval"}, 64'(ivbad), 64'd0);
    chk({tg, "_nwr"}, 64'(nwr), 64'd2);
    chk({tg, "_wa0"}, 64'(wr_a[0]), 64'd1024);
    chk({tg, "_wd0"}, 64'(wr_d[0]), 64'd3);
    chk({tg, "_wa1"}, 64'(wr_a[1]), 64'd1092);
    chk({tg, "_wd1"}, 64'(wr_d[1]), 64'd5);
    chk({tg, "_nrd"}, 64'(nrd), 64'd168);
    chk({tg, "_both"}, 64'(both), 64'd0);
  endtask

  bit ok;

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_n_batch = '0;
    t_ready = 1'b1; infer_valid = 1'b0; infer_type = '0;
    apipe[0] = 16'hFFFF; apipe[1] = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_in_valid", 64'(in_valid), 64'd0);
    chk("rst_t_valid", 64'(t_valid), 64'd0);
    chk("rst_t_last", 64'(t_last), 64'd0);
    chk("rst_addrs", 64'({rd_addr, wr_addr}), 64'd0);
    chk("rst_data", 64'({wr_data, t_data}), 64'd0);
    rst_n = 1'b1;
    clear_mon();

    // T1
    run_job(1, 0, 1'b0, 3000, ok);
    chk("t1_done_seen", 64'(ok), 64'd1);
    check_single("t1");
    chk("t1_rd0", 64'(rd_log[0]), 64'd1028);
    chk("t1_rd32", 64'(rd_log[32]), 64'd0);
    chk("t1_rd33", 64'(rd_log[33]), 64'd4);
    chk("t1_in_c1e0", 64'(in_vec[16*32 +: 32]), 64'd274);
    chk("t1_in_c0e0", 64'(in_vec[0 +: 32]), 64'd257);
    chk("t1_in_c1e15", 64'(in_vec[31*32 +: 32]), 64'd289);
    @(posedge clk); #1;
    chk("t1_done_width", 64'(done), 64'd0);
    chk("t1_busy_after", 64'(busy), 64'd0);
    chk("t1_ndone", 64'(ndone), 64'd1);

    // T2
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1; cfg_n_batch = 16'd0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t2_busy_c1", 64'(busy), 64'd1);
    chk("t2_done_c1", 64'(done), 64'd0);
    @(posedge clk); #1;
    chk("t2_done_c2", 64'(done), 64'd1);
    @(posedge clk); #1;
    chk("t2_done_c3", 64'(done), 64'd0);
    chk("t2_busy_c3", 64'(busy), 64'd0);
    chk("t2_mem", 64'(nrd + nwr), 64'd0);

    // T3
    clear_mon();
    run_job(1, 1, 1'b0, 5000, ok);
    chk("t3_done_seen", 64'(ok), 64'd1);
    check_single("t3");

    // T4
    clear_mon();
    run_job(2, 0, 1'b0, 6000, ok);
    chk("t4_done_seen", 64'(ok), 64'd1);
    chk("t4_xfers", 64'(nx), 64'd256);
    chk("t4_lasts", 64'(nlast), 64'd16);
    chk("t4_order", 64'(serr), 64'd0);
    chk("t4_nwr", 64'(nwr), 64'd4);
    chk("t4_wa2", 64'(wr_a[2]), 64'd1160);
    chk("t4_wd2", 64'(wr_d[2]), 64'd6);
    chk("t4_wa3", 64'(wr_a[3]), 64'd1228);
    chk("t4_wd3", 64'(wr_d[3]), 64'd9);
    chk("t4_load2", 64'(rd_log[168]), 64'd1164);
    chk("t4_retrain", 64'(rd_log[200]), 64'd0);
    chk("t4_nrd", 64'(nrd), 64'd336);

    // T5
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1; cfg_n_batch = 16'd1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2000 && nx < 40; i++) begin
      @(posedge clk); #1;
    end
    chk("t5_reached", 64'(nx >= 40), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_rd_en", 64'(rd_en), 64'd0);
    chk("t5_t_valid", 64'(t_valid), 64'd0);
    chk("t5_in_valid", 64'(in_valid), 64'd0);
    chk("t5_rd_addr", 64'(rd_addr), 64'd0);
    chk("t5_t_data", 64'(t_data), 64'd0);
    repeat (4) @(posedge clk);
    clear_mon();
    run_job(1, 0, 1'b0, 3000, ok);
    chk("t5_done_seen", 64'(ok), 64'd1);
    check_single("t5");

    // T6
    clear_mon();
    run_job(1, 0, 1'b1, 3000, ok);
    chk("t6_done_seen", 64'(ok), 64'd1);
    check_single("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
